hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard unit that consumes the per-instruction register-usage descriptor generated in the D stage: source addresses, destination address, Tuse class and result class. It carries the descriptor through E/M/W shadow registers and derives Tnew per stage. From these it produces the stall, the E-stage bubble and all forwarding-mux selects for the five-stage core. It also owns the multiply/divide busy counter, so HI/LO-dependent instructions stall in D while the md unit is occupied.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult-class start
- DIV_CYC, 10, busy cycles after a div-class start

Ports (clock and reset first):
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; clears all state
- A1_D  in  5  rs address of instruction in D
- A2_D  in  5  rt address of instruction in D
- A3_D  in  5  destination of instruction in D (0 = none)
- Tuse_rs_D  in  2  cycles until rs needed: 0,1,2; 3 = unused
- Tuse_rt_D  in  2  same for rt
- res_D  in  2  result class from define.v: `NW=0, `ALU=1, `DM=2, `PC=3
- md_op_D  in  2  0 none, 1 mult-class start, 2 div-class start, 3 HI/LO access
- stall  out  1  freeze PC and F/D register
- clrE  out  1  load bubble into D/E (equals stall)
- fwd_rs_D, fwd_rt_D  out  2 each  D compare operands: 0 regfile, 1 E, 2 M, 3 W
- fwd_rs_E, fwd_rt_E  out  2 each  ALU operands: 0 pipe value, 2 M, 3 W
- fwd_rt_M  out  2  store data: 0 pipe value, 3 W
- md_start  out  1  start op currently in E
- md_busy  out  1  md counter nonzero

## Operation
- Shadow registers: E holds A1/A2/A3/res/md_op; M holds A2/A3/res; W holds A3/res. Each updates every cycle. E loads zero (bubble) when clrE=1.
- Tnew: E: ALU→1, DM→2, PC→0, NW→0. M: DM→1, else 0. W: 0.
- A producer matches a source iff its A3 ≠ 0, its A3 equals the source address, and its res ≠ NW.
- Register stall: any matching E or M producer has Tuse (≠3) < Tnew at that stage.
- md stall: md_op_D ≠ 0 and (md_start or md_busy).
- stall = register stall OR md stall.
- Forwarding is selected only from a matching producer with Tnew 0 at that stage, nearest stage first:
  - E is eligible only when res_E = PC.
  - M is eligible when res_M ∈ {ALU, PC}.
  - W is eligible for any res ≠ NW.
  - With no match, select 0. Address 0 never forwards.
- md counter: when md_start (E md_op 1 or 2), load MULT_CYC or DIV_CYC at the next edge, then decrement to 0. A start while busy cannot occur, because it is stalled in D.

## Timing
- All outputs are combinational from D inputs and registered state. There is no added latency.
- After reset: all shadow registers and the counter are 0. stall=clrE=0, all fwd=0, md_start=md_busy=0.
- Stall holds until the producer advances far enough: lw→beq takes 2 cycles, lw→addu 1 cycle, addu→beq 1 cycle.
- mult issued at cycle t enters E at t+1 (md_start=1). md_busy is 1 over t+2..t+6. mfhi in D stalls through t+6 and issues at t+7.
- A reset in the same cycle as stall wins: all state clears and the next cycle shows stall=0.
- Stall and a W-stage match together: stall dominates and fwd values are don't-care. The bench checks fwd only when stall=0.

## Structure
- Result-class codes (`NW/`ALU/`DM/`PC), Tuse "unused"=3, fwd select codes and md_op codes live in the shared define.v.
- One sub-module, hazard_pipe, holds the E/M/W shadow registers with the clear input. Stall, forward and md-counter logic sits in hazard_ctrl.

## Test plan
- lw $1 (res DM, A3=1) then beq $1 (Tuse_rs 0) → stall=clrE=1 for 2 cycles, then fwd_rs_D=3.
- addu $3 then addu using $3 (Tuse_rs 1) → no stall; next cycle fwd_rs_E=2.
- jal (A3=31, res PC) then jr $31 (Tuse_rs 0) → no stall, fwd_rs_D=1.
- lw $5 then sw $5 (Tuse_rt 2) → no stall; sw in M sees fwd_rt_M=3.
- div, then mflo (md_op 3) → stall for 11 cycles (1 md_start + DIV_CYC busy), then release.
- Writer to $0 followed by a reader of $0 → never stall, all fwd=0. Reset asserted mid-stall → next cycle all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard unit: result classes, md op classes, forward selects,
// and the per-stage descriptor layouts carried by the shadow pipeline.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RES_NW  = 2'd0,
        RES_ALU = 2'd1,
        RES_DM  = 2'd2,
        RES_PC  = 2'd3
    } res_t;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_HILO = 2'd3
    } md_t;

    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        res_t       res;
        md_t        md_op;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] a2;
        logic [4:0] a3;
        res_t       res;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        res_t       res;
    } w_stage_t;

    function automatic logic producer_match(input logic [4:0] a3, input res_t res,
                                            input logic [4:0] src);
        return (a3 != 5'd0) && (a3 == src) && (res != RES_NW);
    endfunction

    function automatic logic [1:0] tnew_e(input res_t res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input res_t res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_pipe.sv
// E/M/W shadow copies of the D-stage register-usage descriptor.
// E takes a bubble when clr_i is high; M and W always advance.
module hazard_pipe
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic [4:0] a1_i,
    input  logic [4:0] a2_i,
    input  logic [4:0] a3_i,
    input  logic [1:0] res_i,
    input  logic [1:0] md_op_i,
    output e_stage_t   e_o,
    output m_stage_t   m_o,
    output w_stage_t   w_o
);

    e_stage_t e_q, e_d;
    m_stage_t m_q, m_d;
    w_stage_t w_q, w_d;

    always_comb begin
        e_d = '0;
        if (!clr_i) begin
            e_d.a1    = a1_i;
            e_d.a2    = a2_i;
            e_d.a3    = a3_i;
            e_d.res   = res_t'(res_i);
            e_d.md_op = md_t'(md_op_i);
        end
        m_d.a2  = e_q.a2;
        m_d.a3  = e_q.a3;
        m_d.res = e_q.res;
        w_d.a3  = m_q.a3;
        w_d.res = m_q.res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign e_o = e_q;
    assign m_o = m_q;
    assign w_o = w_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage core hazard unit: stall/bubble generation, forwarding selects for D/E/M
// consumers, and the multiply/divide busy counter that holds HI/LO users in D.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [1:0] res_D,
    input  logic [1:0] md_op_D,
    output logic       stall,
    output logic       clrE,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic [1:0] fwd_rt_M,
    output logic       md_start,
    output logic       md_busy
);

    localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    e_stage_t e_s;
    m_stage_t m_s;
    w_stage_t w_s;

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             reg_stall, md_stall;

    hazard_pipe u_pipe (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clrE),
        .a1_i   (A1_D),
        .a2_i   (A2_D),
        .a3_i   (A3_D),
        .res_i  (res_D),
        .md_op_i(md_op_D),
        .e_o    (e_s),
        .m_o    (m_s),
        .w_o    (w_s)
    );

    // A source stalls when the value it needs is produced later than it is consumed.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input e_stage_t e, input m_stage_t m);
        if (tuse == TUSE_UNUSED) return 1'b0;
        return (producer_match(e.a3, e.res, src) && (tuse < tnew_e(e.res))) ||
               (producer_match(m.a3, m.res, src) && (tuse < tnew_m(m.res)));
    endfunction

    function automatic logic [1:0] sel_fwd_d(input logic [4:0] src, input e_stage_t e,
                                             input m_stage_t m, input w_stage_t w);
        if (producer_match(e.a3, e.res, src) && (tnew_e(e.res) == 2'd0)) return FWD_E;
        if (producer_match(m.a3, m.res, src) && (tnew_m(m.res) == 2'd0)) return FWD_M;
        if (producer_match(w.a3, w.res, src)) return FWD_W;
        return FWD_NONE;
    endfunction

    function automatic logic [1:0] sel_fwd_e(input logic [4:0] src, input m_stage_t m,
                                             input w_stage_t w);
        if (producer_match(m.a3, m.res, src) && (tnew_m(m.res) == 2'd0)) return FWD_M;
        if (producer_match(w.a3, w.res, src)) return FWD_W;
        return FWD_NONE;
    endfunction

    function automatic logic [1:0] sel_fwd_m(input logic [4:0] src, input w_stage_t w);
        return producer_match(w.a3, w.res, src) ? FWD_W : FWD_NONE;
    endfunction

    assign md_start = (e_s.md_op == MD_MULT) || (e_s.md_op == MD_DIV);
    assign md_busy  = (md_cnt_q != '0);

    always_comb begin
        reg_stall = reg_hazard(A1_D, Tuse_rs_D, e_s, m_s) ||
                    reg_hazard(A2_D, Tuse_rt_D, e_s, m_s);
        md_stall  = (md_t'(md_op_D) != MD_NONE) && (md_start || md_busy);
        stall     = reg_stall || md_stall;
        clrE      = stall;
        fwd_rs_D  = sel_fwd_d(A1_D, e_s, m_s, w_s);
        fwd_rt_D  = sel_fwd_d(A2_D, e_s, m_s, w_s);
        fwd_rs_E  = sel_fwd_e(e_s.a1, m_s, w_s);
        fwd_rt_E  = sel_fwd_e(e_s.a2, m_s, w_s);
        fwd_rt_M  = sel_fwd_m(m_s.a2, w_s);
    end

    // Busy counter: loaded while the start op sits in E, then counts down to idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_s.md_op == MD_MULT) begin
            md_cnt_d = CNT_W'(MULT_CYC);
        end else if (e_s.md_op == MD_DIV) begin
            md_cnt_d = CNT_W'(DIV_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued as each D-stage
// instruction is driven and compared at the following falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, res_D, md_op_D;
    logic       stall, clrE, md_start, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .A1_D     (A1_D),
        .A2_D     (A2_D),
        .A3_D     (A3_D),
        .Tuse_rs_D(Tuse_rs_D),
        .Tuse_rt_D(Tuse_rt_D),
        .res_D    (res_D),
        .md_op_D  (md_op_D),
        .stall    (stall),
        .clrE     (clrE),
        .fwd_rs_D (fwd_rs_D),
        .fwd_rt_D (fwd_rt_D),
        .fwd_rs_E (fwd_rs_E),
        .fwd_rt_E (fwd_rt_E),
        .fwd_rt_M (fwd_rt_M),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [1:0] res, input logic [1:0] md);
        A1_D = a1; A2_D = a2; A3_D = a3;
        Tuse_rs_D = trs; Tuse_rt_D = trt; res_D = res; md_op_D = md;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 2'd0);
    endtask

    // clrE is always expected to equal stall.
    task automatic expect_o(input string tag, input logic st, input logic ms, input logic mb,
                            input logic [1:0] frsd, input logic [1:0] frtd,
                            input logic [1:0] frse, input logic [1:0] frte,
                            input logic [1:0] frtm);
        exp_t e;
        e.tag = tag;
        e.v   = {st, st, ms, mb, frsd, frtd, frse, frte, frtm};
        sb.push_back(e);
    endtask

    task automatic z(input string tag);
        expect_o(tag, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic tick();
        exp_t        e;
        logic [13:0] obs;
        logic [13:0] expv;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e    = sb.pop_front();
            obs  = {stall, clrE, md_start, md_busy,
                    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M};
            expv = e.v;
            if (expv[13]) begin
                obs[9:0]  = '0;
                expv[9:0] = '0;
            end
            assert (obs === expv) passed++;
            else $error("FAIL %s observed=%b expected=%b", e.tag, obs, expv);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        z("rst_hold");
        tick();
        reset = 1'b0;
        z("rst_idle");
        tick();

        // lw $1 -> beq $1: two stall cycles, then W forward
        drive(5'd2, 5'd0, 5'd1, 2'd1, 2'd3, 2'd2, 2'd0); z("lw1");        tick();
        drive(5'd1, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        expect_o("lwbeq_s1", 1, 0, 0, 0, 0, 0, 0, 0);                      tick();
        expect_o("lwbeq_s2", 1, 0, 0, 0, 0, 0, 0, 0);                      tick();
        expect_o("lwbeq_go", 0, 0, 0, 2'd3, 0, 0, 0, 0);                   tick();
        nop(); z("lwbeq_f1"); tick(); z("lwbeq_f2"); tick(); z("lwbeq_f3"); tick();

        // addu $3 -> addu $4,$3: no stall, M forward into E
        drive(5'd1, 5'd2, 5'd3, 2'd1, 2'd1, 2'd1, 2'd0); z("addu1");       tick();
        drive(5'd3, 5'd0, 5'd4, 2'd1, 2'd1, 2'd1, 2'd0); z("addu_dep");    tick();
        nop(); expect_o("addu_fwdE", 0, 0, 0, 0, 0, 2'd2, 0, 0);           tick();
        z("addu_f1"); tick(); z("addu_f2"); tick();

        // addu $6, gap, reader of $6 in rt: M forward in D, then W forward in E
        drive(5'd0, 5'd0, 5'd6, 2'd3, 2'd3, 2'd1, 2'd0); z("w6");          tick();
        nop(); z("w6_gap");                                                tick();
        drive(5'd0, 5'd6, 5'd7, 2'd3, 2'd1, 2'd1, 2'd0);
        expect_o("w6_fwdD", 0, 0, 0, 0, 2'd2, 0, 0, 0);                    tick();
        nop(); expect_o("w6_fwdE", 0, 0, 0, 0, 0, 0, 2'd3, 0);             tick();
        z("w6_f1"); tick(); z("w6_f2"); tick();

        // addu $7 -> beq $7: one stall cycle
        drive(5'd0, 5'd0, 5'd7, 2'd3, 2'd3, 2'd1, 2'd0); z("add7");        tick();
        drive(5'd7, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        expect_o("addbeq_s", 1, 0, 0, 0, 0, 0, 0, 0);                      tick();
        expect_o("addbeq_go", 0, 0, 0, 2'd2, 0, 0, 0, 0);                  tick();
        nop(); expect_o("addbeq_E", 0, 0, 0, 0, 0, 2'd3, 0, 0);            tick();
        z("addbeq_f1"); tick(); z("addbeq_f2"); tick();

        // jal -> jr $31: E forward, no stall
        drive(5'd0, 5'd0, 5'd31, 2'd3, 2'd3, 2'd3, 2'd0); z("jal");        tick();
        drive(5'd31, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        expect_o("jr_fwdD", 0, 0, 0, 2'd1, 0, 0, 0, 0);                    tick();
        nop(); expect_o("jr_fwdE", 0, 0, 0, 0, 0, 2'd2, 0, 0);             tick();
        z("jr_f1"); tick(); z("jr_f2"); tick();

        // lw $5 -> sw $5: no stall, store data forwarded from W in M
        drive(5'd2, 5'd0, 5'd5, 2'd1, 2'd3, 2'd2, 2'd0); z("lw5");         tick();
        drive(5'd2, 5'd5, 5'd0, 2'd1, 2'd2, 2'd0, 2'd0); z("sw_D");        tick();
        nop(); z("sw_E");                                                  tick();
        expect_o("sw_M", 0, 0, 0, 0, 0, 0, 0, 2'd3);                       tick();
        z("sw_f1"); tick();

        // $0 writer and readers never interact
        drive(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd1, 2'd0); z("w0");          tick();
        drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        z("r0_a"); tick(); z("r0_b"); tick(); z("r0_c"); tick();
        nop(); z("r0_f1"); tick();

        // div -> mflo: 1 start cycle + 10 busy cycles of stall
        drive(5'd8, 5'd9, 5'd0, 2'd1, 2'd1, 2'd0, 2'd2); z("div");         tick();
        drive(5'd0, 5'd0, 5'd10, 2'd3, 2'd3, 2'd1, 2'd3);
        expect_o("div_start", 1, 1, 0, 0, 0, 0, 0, 0);                     tick();
        for (int i = 0; i < 10; i++) begin
            expect_o($sformatf("div_busy%0d", i), 1, 0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        z("div_go"); tick();
        nop(); z("div_f1"); tick(); z("div_f2"); tick();

        // mult -> mfhi: 1 start cycle + 5 busy cycles
        drive(5'd8, 5'd9, 5'd0, 2'd1, 2'd1, 2'd0, 2'd1); z("mult");        tick();
        drive(5'd0, 5'd0, 5'd11, 2'd3, 2'd3, 2'd1, 2'd3);
        expect_o("mult_start", 1, 1, 0, 0, 0, 0, 0, 0);                    tick();
        for (int i = 0; i < 5; i++) begin
            expect_o($sformatf("mult_busy%0d", i), 1, 0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        z("mult_go"); tick();
        nop(); z("mult_f1"); tick(); z("mult_f2"); tick();

        // reset during a register stall
        drive(5'd2, 5'd0, 5'd1, 2'd1, 2'd3, 2'd2, 2'd0); z("rs_lw");       tick();
        drive(5'd1, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        expect_o("rstmid_s", 1, 0, 0, 0, 0, 0, 0, 0);                      tick();
        reset = 1'b1;
        expect_o("rstmid_s2", 1, 0, 0, 0, 0, 0, 0, 0);                     tick();
        reset = 1'b0;
        z("rstmid_clr"); tick();
        nop(); z("rstmid_f1"); tick();

        // reset while the md counter is busy
        drive(5'd8, 5'd9, 5'd0, 2'd1, 2'd1, 2'd0, 2'd2); z("rd_div");      tick();
        drive(5'd0, 5'd0, 5'd10, 2'd3, 2'd3, 2'd1, 2'd3);
        expect_o("rstmd_start", 1, 1, 0, 0, 0, 0, 0, 0);                   tick();
        expect_o("rstmd_b0", 1, 0, 1, 0, 0, 0, 0, 0);                      tick();
        reset = 1'b1;
        expect_o("rstmd_b1", 1, 0, 1, 0, 0, 0, 0, 0);                      tick();
        reset = 1'b0;
        z("rstmd_clr"); tick();
        nop(); z("rstmd_f1"); tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
